// File: rtl/fdn_coef_loader.sv
// Streams one beamforming coefficient set from a banked RAM into FDN_core_x,
// channel-fastest, with a credit-limited read-ahead FIFO that honours coef_ready.
module fdn_coef_loader #(
  parameter int wight_coef_i = 24,
  parameter int N_chanals    = 32,
  parameter int N_DN         = 72,
  parameter int BANKS        = 2,
  parameter int RD_LAT       = 2,
  localparam int ADDR_W = $clog2(BANKS*N_chanals*N_DN),
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int NLD_W  = $clog2(N_DN+1),
  localparam int DN_W   = (N_DN > 1) ? $clog2(N_DN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BANK_W-1:0]       bank_sel,
  input  logic [NLD_W-1:0]        n_dn_load,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    err_start,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [wight_coef_i-1:0] mem_re,
  input  logic [wight_coef_i-1:0] mem_im,
  input  logic                    coef_ready,
  output logic                    vld_coef_out,
  output logic                    last_coef_out,
  output logic [wight_coef_i-1:0] coefReOut,
  output logic [wight_coef_i-1:0] coefImOut,
  output logic [DN_W-1:0]         cur_dn
);
  localparam int FIFO_D = RD_LAT + 2;
  localparam int CH_W   = (N_chanals > 1) ? $clog2(N_chanals) : 1;
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = $clog2(FIFO_D+1);
  localparam int FL_W   = $clog2(RD_LAT+1);
  localparam int SET_SZ = N_chanals * N_DN;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_FLUSH} state_t;

  state_t                              state_q, state_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [DN_W-1:0]                     k_q, k_d;
  logic [CH_W-1:0]                     rd_ch_q, rd_ch_d, out_ch_q, out_ch_d;
  logic [DN_W-1:0]                     rd_dn_q, rd_dn_d, out_dn_q, out_dn_d;
  logic [RD_LAT-1:0]                   rd_pipe_q, rd_pipe_d;
  logic [FIFO_D-1:0][wight_coef_i-1:0] fifo_re_q, fifo_re_d, fifo_im_q, fifo_im_d;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [FL_W-1:0]                     fl_cnt_q, fl_cnt_d;
  logic                                busy_q, busy_d, done_q, done_d;
  logic                                aborted_q, aborted_d, err_start_q, err_start_d;
  logic                                vld_q, vld_d, last_q, last_d;
  logic [wight_coef_i-1:0]             re_q, re_d, im_q, im_d;
  logic [DN_W-1:0]                     cur_dn_q, cur_dn_d;

  logic             active, flush, ret_vld, credit, rd_en, from_fifo, pop, push, popf, rd_last;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   occ;
  logic [NLD_W-1:0] n_clamp;

  always_comb begin
    state_d = state_q;   addr_d = addr_q;       k_d = k_q;
    rd_ch_d = rd_ch_q;   rd_dn_d = rd_dn_q;     out_ch_d = out_ch_q;  out_dn_d = out_dn_q;
    fifo_re_d = fifo_re_q;  fifo_im_d = fifo_im_q;
    wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;   cnt_d = cnt_q;        fl_cnt_d = fl_cnt_q;
    re_d = re_q;         im_d = im_q;           cur_dn_d = cur_dn_q;
    vld_d = 1'b0;        last_d = 1'b0;

    active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    flush   = (active && abort) || (state_q == S_FLUSH);
    ret_vld = rd_pipe_q[RD_LAT-1];
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(rd_pipe_q[i]);
    // Reads in flight hold a FIFO slot so returning data can never overflow it.
    occ     = {1'b0, cnt_q} + {1'b0, inflight};
    credit  = occ < (CNT_W+1)'(FIFO_D);
    rd_en   = (state_q == S_RUN) && !abort && coef_ready && credit;
    rd_last = rd_en && (rd_ch_q == CH_W'(N_chanals-1)) && (rd_dn_q == k_q);
    from_fifo = (cnt_q != '0);
    // An empty FIFO forwards the arriving RAM word straight to the output register.
    pop     = active && !abort && coef_ready && (from_fifo || ret_vld);
    popf    = pop && from_fifo;
    push    = ret_vld && !flush && !(pop && !from_fifo);

    rd_pipe_d = RD_LAT'({rd_pipe_q, rd_en});
    if (rd_en) begin
      addr_d = addr_q + 1'b1;
      if (rd_ch_q == CH_W'(N_chanals-1)) begin
        rd_ch_d = '0;
        rd_dn_d = rd_dn_q + 1'b1;
      end else rd_ch_d = rd_ch_q + 1'b1;
    end

    if (push) begin
      fifo_re_d[wr_ptr_q] = mem_re;
      fifo_im_d[wr_ptr_q] = mem_im;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_D-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (popf) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_D-1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !popf)      cnt_d = cnt_q + 1'b1;
    else if (!push && popf) cnt_d = cnt_q - 1'b1;
    if (flush) begin
      wr_ptr_d = '0; rd_ptr_d = '0; cnt_d = '0;
    end

    if (pop) begin
      vld_d    = 1'b1;
      re_d     = from_fifo ? fifo_re_q[rd_ptr_q] : mem_re;
      im_d     = from_fifo ? fifo_im_q[rd_ptr_q] : mem_im;
      cur_dn_d = out_dn_q;
      last_d   = (out_ch_q == CH_W'(N_chanals-1)) && (out_dn_q == k_q);
      if (out_ch_q == CH_W'(N_chanals-1)) begin
        out_ch_d = '0;
        out_dn_d = out_dn_q + 1'b1;
      end else out_ch_d = out_ch_q + 1'b1;
    end

    n_clamp = ((n_dn_load == '0) || (n_dn_load > NLD_W'(N_DN))) ? NLD_W'(N_DN) : n_dn_load;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        addr_d  = ADDR_W'(bank_sel) * ADDR_W'(SET_SZ);
        k_d     = DN_W'(n_clamp - 1'b1);
        rd_ch_d = '0; rd_dn_d = '0; out_ch_d = '0; out_dn_d = '0;
      end
      S_RUN:   if (abort) begin state_d = S_FLUSH; fl_cnt_d = '0; end
               else if (rd_last) state_d = S_DRAIN;
      S_DRAIN: if (abort) begin state_d = S_FLUSH; fl_cnt_d = '0; end
               else if (last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FLUSH: if (fl_cnt_q == FL_W'(RD_LAT)) state_d = S_IDLE;
               else fl_cnt_d = fl_cnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    aborted_d   = (state_d == S_FLUSH) && (fl_cnt_d == FL_W'(RD_LAT));
    err_start_d = start && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  addr_q <= '0;   k_q <= '0;
      rd_ch_q <= '0;      rd_dn_q <= '0;  out_ch_q <= '0;  out_dn_q <= '0;
      rd_pipe_q <= '0;    fifo_re_q <= '0; fifo_im_q <= '0;
      wr_ptr_q <= '0;     rd_ptr_q <= '0; cnt_q <= '0;     fl_cnt_q <= '0;
      busy_q <= 1'b0;     done_q <= 1'b0; aborted_q <= 1'b0; err_start_q <= 1'b0;
      vld_q <= 1'b0;      last_q <= 1'b0; re_q <= '0;      im_q <= '0;  cur_dn_q <= '0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; k_q <= k_d;
      rd_ch_q <= rd_ch_d; rd_dn_q <= rd_dn_d; out_ch_q <= out_ch_d; out_dn_q <= out_dn_d;
      rd_pipe_q <= rd_pipe_d; fifo_re_q <= fifo_re_d; fifo_im_q <= fifo_im_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; cnt_q <= cnt_d; fl_cnt_q <= fl_cnt_d;
      busy_q <= busy_d;   done_q <= done_d; aborted_q <= aborted_d; err_start_q <= err_start_d;
      vld_q <= vld_d;     last_q <= last_d; re_q <= re_d;  im_q <= im_d;  cur_dn_q <= cur_dn_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign err_start     = err_start_q;
  assign mem_rd_en     = rd_en;
  assign mem_addr      = addr_q;
  assign vld_coef_out  = vld_q;
  assign last_coef_out = last_q;
  assign coefReOut     = re_q;
  assign coefImOut     = im_q;
  assign cur_dn        = cur_dn_q;
endmodule
